// File: rtl/adder_pipe.sv
// Two-stage pipelined adder/subtractor with valid/ready handshakes on both sides.
// Optional macro ADDER_PIPE_SAT_EN enables unsigned saturation of s in stage 2.
module adder_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int H = WIDTH / 2;

  // Handshake: a transfer happens on a side when its valid and ready are both 1
  // at a rising edge. valid never waits on ready; in_ready never looks at in_valid.

  logic             v1;
  logic [H-1:0]     lo1;
  logic             c1;
  logic [H-1:0]     a_hi1;
  logic [H-1:0]     b_hi1;
`ifdef ADDER_PIPE_SAT_EN
  logic             op1;
`endif

  logic             adv2;
  logic [WIDTH-1:0] bp;
  logic             c0;
  logic [H:0]       lo_full;
  logic [H:0]       hi_full;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_next;
  logic             cout_raw;
  logic             ovf_raw;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !v1 || adv2;

  // Subtract is a + ~b + 1; cin only matters for add.
  always_comb begin
    bp      = op ? ~b : b;
    c0      = op ? 1'b1 : cin;
    lo_full = {1'b0, a[H-1:0]} + {1'b0, bp[H-1:0]} + {{H{1'b0}}, c0};
  end

  always_comb begin
    hi_full  = {1'b0, a_hi1} + {1'b0, b_hi1} + {{H{1'b0}}, c1};
    s_raw    = {hi_full[H-1:0], lo1};
    cout_raw = hi_full[H];
    ovf_raw  = (a_hi1[H-1] == b_hi1[H-1]) && (hi_full[H-1] != a_hi1[H-1]);
    s_next   = s_raw;
`ifdef ADDER_PIPE_SAT_EN
    // Unsigned clamp; cout/ovf still report the raw sum.
    if (!op1 && cout_raw)
      s_next = '1;
    else if (op1 && !cout_raw)
      s_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      lo1   <= '0;
      c1    <= 1'b0;
      a_hi1 <= '0;
      b_hi1 <= '0;
`ifdef ADDER_PIPE_SAT_EN
      op1   <= 1'b0;
`endif
    end else if (in_ready) begin
      v1 <= in_valid;
      if (in_valid) begin
        lo1   <= lo_full[H-1:0];
        c1    <= lo_full[H];
        a_hi1 <= a[WIDTH-1:H];
        b_hi1 <= bp[WIDTH-1:H];
`ifdef ADDER_PIPE_SAT_EN
        op1   <= op;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (adv2) begin
      out_valid <= v1;
      if (v1) begin
        s    <= s_next;
        cout <= cout_raw;
        ovf  <= ovf_raw;
      end
    end
  end

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe (WIDTH=8): vector table plus stall, ordering and reset sequences.
module tb_adder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] s;
  logic       cout;
  logic       ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       op;
    logic [7:0] s;
    logic [7:0] s_sat;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  adder_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                       input logic tc, input logic top, input logic ordy);
    in_valid  = v;
    a         = ta;
    b         = tb_;
    cin       = tc;
    op        = top;
    out_ready = ordy;
  endtask

  task automatic run_vec(input vec_t v);
    logic [7:0] es;
`ifdef ADDER_PIPE_SAT_EN
    es = v.s_sat;
`else
    es = v.s;
`endif
    @(negedge clk);
    drive(1'b1, v.a, v.b, v.cin, v.op, 1'b1);
    #1 check("vec_in_ready", in_ready, 1);
    @(negedge clk);
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 check("vec_latency_not_early", out_valid, 0);
    @(negedge clk);
    #1;
    check("vec_out_valid", out_valid, 1);
    check("vec_s", s, es);
    check("vec_cout", cout, v.cout);
    check("vec_ovf", ovf, v.ovf);
  endtask

  initial begin
    logic [7:0] held_s;
    logic       prev_stall;
    int         idx;
    int         out_cnt;

    //            a      b      cin   op    s      s_sat  cout  ovf
    vecs[0]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[3]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b1};
    vecs[5]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 8'h31, 1'b0, 1'b0};
    vecs[6]  = '{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0};
    vecs[7]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h7F, 1'b1, 1'b1};
    vecs[8]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[9]  = '{8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 8'hFF, 1'b1, 1'b0};
    vecs[10] = '{8'h05, 8'h03, 1'b1, 1'b1, 8'h02, 8'h02, 1'b1, 1'b0};
    vecs[11] = '{8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0};

    // Reset for two cycles, then check the idle state.
    rst = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Four back-to-back adds with the consumer stalled for the first 3 cycles.
    @(negedge clk);
    idx = 0;
    out_cnt = 0;
    prev_stall = 1'b0;
    held_s = 8'h00;
    for (int cyc = 0; cyc < 20 && out_cnt < 4; cyc++) begin
      if (cyc > 0) @(negedge clk);
      drive(idx < 4, 8'(idx + 1), 8'(idx + 1), 1'b0, 1'b0, cyc >= 3);
      #1;
      if (cyc == 2) check("stall_in_ready_low", in_ready, 0);
      if (prev_stall) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_s", s, held_s);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("stall_unexpected_out", s, 8'hxx);
        else check("stall_order_s", s, exp_q.pop_front());
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      held_s = s;
      if (in_valid && in_ready) begin
        exp_q.push_back(8'(2 * (idx + 1)));
        idx++;
      end
    end
    check("stall_out_count", out_cnt, 4);
    check("stall_queue_empty", exp_q.size(), 0);

    // Reset while two transactions are in flight; nothing stale may emerge.
    @(negedge clk);
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1 check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    drive(1'b1, 8'h55, 8'h66, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1 check("mid_rst_out_valid", out_valid, 0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
    #1 check("post_rst_in_ready", in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1 check("post_rst_no_stale", out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
